bus_master_join: RTL and testbench
==================================

# bus_master_join

Initiator end of the broadcast slave-task bus: accepts one read or write command at a time from upstream and broadcasts it to `N` slave ports in parallel. It then waits until every enabled slave has signalled completion, the join, before returning a single merged response. It sits between the system-side command source and the slave-side `slave_write`/`slave_read` responders, and is the synthesizable hardware counterpart of the fork-join task call.

## Interface
Parameters:
- `N`, default 4: number of slave ports (1..32).
- `AW`, default 8: address width.
- `DW`, default 8: data width.
- `TIMEOUT`, default 64: maximum cycles spent in JOIN (2..1024).

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write (`slave_write`), 0 = read (`slave_read`).
- `cmd_addr` in AW: address.
- `cmd_wdata` in DW: write data.
- `rsp_valid` out 1: response held until `rsp_ready`.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out DW: read data.
- `rsp_err` out 2: 0 OK, 1 no hit, 2 multi hit, 3 timeout.
- `slv_en` in N: per-slave participation, sampled in ISSUE.
- `req` out 1: one-cycle broadcast strobe.
- `req_write`, `req_addr`, `req_wdata` out 1/AW/DW: broadcast command, stable from ISSUE until return to IDLE.
- `slv_done` in N: per-slave completion pulse.
- `slv_hit` in N: slave owns the address; qualified by `slv_done`.
- `slv_rdata` in N*DW: slave `i` read data in bits [i*DW +: DW]; qualified by `slv_done[i]`.

## Operation
- FSM states: IDLE, ISSUE, JOIN, RESP. Reset enters IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On handshake, latch write/addr/wdata onto `req_*` and go to ISSUE.
- ISSUE:
  - `req`=1 for exactly this cycle.
  - Load `pending` = `slv_en`; clear `hit_seen`, `hit_cnt` and the timer. Go to JOIN.
- JOIN:
  - For each `i` with `slv_done[i] & pending[i]`: clear `pending[i]`.
  - If `slv_hit[i]` is also set, set `hit_seen[i]` and increment `hit_cnt` (saturating at 2).
  - Capture `slv_rdata[i]` only for the lowest-index hit seen so far.
  - Repeat `done` pulses from an already-completed slave are ignored.
  - `done` from slaves with `slv_en`=0 is ignored.
  - Leave for RESP when `pending` is all-zero after this cycle's update, or when the timer reaches TIMEOUT-1.
  - If both occur in the same cycle, completion wins.
- Error merge, with priority timeout > multi hit > no hit > OK:
  - `hit_cnt`==0 gives 1.
  - `hit_cnt`>=2 gives 2; `rdata` is taken from the lowest-index hitting slave.
  - Timeout gives 3; `rdata`=0.
  - Writes use the same hit rules; `rsp_rdata`=0 for writes.
- RESP: `rsp_valid`=1 with `rsp_rdata`/`rsp_err` stable until `rsp_ready`, then go to IDLE.
- `slv_en` all-zero: JOIN exits after one cycle with `rsp_err`=1.
- `slv_done`/`slv_hit` outside JOIN are ignored.
- Reset mid-operation:
  - FSM goes to IDLE and all state clears.
  - An outstanding `req` is abandoned; late `done` pulses are ignored.

## Timing
- Outputs during and after reset: `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `req`=0, `req_write`=0, `req_addr`=0, `req_wdata`=0.
- `cmd_ready` is 0 while `reset` is high and 1 from the first cycle after reset deasserts.
- Command accepted in cycle T: `req` is high in T+1, and JOIN starts in T+2.
- If all `slv_done` arrive in T+2, `rsp_valid` rises in T+3. This is the minimum latency of 3.
- Slaves must not assert `done` in the ISSUE cycle.
- Timeout: no completion gives `rsp_valid` in T+2+TIMEOUT.
- `rsp_ready` high in the first RESP cycle gives IDLE next cycle, so back-to-back commands issue every 4 cycles minimum.
- `cmd_ready` is a decode of state only. It has no combinational path from `cmd_valid` or `rsp_ready`.

## Test plan
- Write, `N`=4, `slv_en`=4'b1111, addr 0x10, data 0xA5; slaves 0..3 pulse `done` at T+2, T+3, T+3, T+5 with only slave 2 hit -> `req` one cycle at T+1, `rsp_valid` at T+6, `rsp_err`=0.
- Read addr 0x20; slave 1 hit with rdata 0x5C, other enabled slaves done without hit, all in T+2 -> `rsp_rdata`=0x5C, `rsp_err`=0, `rsp_valid` at T+3.
- Read where slaves 1 and 3 hit (data 0x11, 0x33) -> `rsp_err`=2, `rsp_rdata`=0x11; read with no hits -> `rsp_err`=1.
- Slave 3 never completes, `TIMEOUT`=64 -> `rsp_valid` at T+66, `rsp_err`=3, `rsp_rdata`=0.
- Slave 3 completes on the timeout cycle -> `rsp_err`=0.
- `slv_en`=4'b0101 with slaves 1 and 3 silent -> completes on slaves 0 and 2 only; duplicate `done` from slave 0 has no effect; `slv_en`=0 -> `rsp_err`=1 at T+3.
- `reset` asserted during JOIN, then late `done` pulses -> all outputs at reset values and no spurious response; `rsp_ready` held low 5 cycles -> response held stable and `cmd_ready`=0 throughout.

Source files
------------

// File: rtl/bus_master_join.sv
// Initiator side of the broadcast slave-task bus: issues one command to all
// slave ports, joins on every enabled slave's completion, returns one merged response.
//
// state | meaning
// IDLE  | waiting for an upstream command, cmd_ready high
// ISSUE | one-cycle broadcast strobe, join bookkeeping initialised
// JOIN  | collecting done/hit/rdata from enabled slaves until all done or timeout
// RESP  | merged response held until rsp_ready
module bus_master_join #(
    parameter int N       = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic [1:0]      rsp_err,
    input  logic [N-1:0]    slv_en,
    output logic            req,
    output logic            req_write,
    output logic [AW-1:0]   req_addr,
    output logic [DW-1:0]   req_wdata,
    input  logic [N-1:0]    slv_done,
    input  logic [N-1:0]    slv_hit,
    input  logic [N*DW-1:0] slv_rdata
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, JOIN, RESP} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    hit_seen_q, hit_seen_d;
    logic [1:0]      hit_cnt_q, hit_cnt_d;
    logic [DW-1:0]   cap_q, cap_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      err_q, err_d;
    logic            found;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            hit_seen_q <= '0;
            hit_cnt_q  <= '0;
            cap_q      <= '0;
            timer_q    <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            hit_seen_q <= hit_seen_d;
            hit_cnt_q  <= hit_cnt_d;
            cap_q      <= cap_d;
            timer_q    <= timer_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        hit_seen_d = hit_seen_q;
        hit_cnt_d  = hit_cnt_q;
        cap_d      = cap_q;
        timer_d    = timer_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        found      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    wr_d    = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pending_d  = slv_en;
                hit_seen_d = '0;
                hit_cnt_d  = '0;
                cap_d      = '0;
                timer_d    = TW'(TIMEOUT - 1);
                state_d    = JOIN;
            end
            JOIN: begin
                for (int i = 0; i < N; i++) begin
                    if (slv_done[i] && pending_q[i]) begin
                        pending_d[i] = 1'b0;
                        if (slv_hit[i]) begin
                            hit_seen_d[i] = 1'b1;
                            if (hit_cnt_d != 2'd2)
                                hit_cnt_d = hit_cnt_d + 2'd1;
                        end
                    end
                end
                // Only a newly arrived hit that is now the lowest index replaces the capture.
                for (int i = 0; i < N; i++) begin
                    if (!found && hit_seen_d[i]) begin
                        found = 1'b1;
                        if (!hit_seen_q[i])
                            cap_d = slv_rdata[i*DW +: DW];
                    end
                end
                if (pending_d == '0) begin
                    state_d = RESP;
                    rdata_d = wr_q ? '0 : cap_d;
                    if (hit_cnt_d == 2'd0)
                        err_d = 2'd1;
                    else if (hit_cnt_d == 2'd2)
                        err_d = 2'd2;
                    else
                        err_d = 2'd0;
                end else if (timer_q == '0) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 2'd3;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE)  && !reset;
    assign req       = (state_q == ISSUE) && !reset;
    assign rsp_valid = (state_q == RESP)  && !reset;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign req_write = wr_q;
    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;
endmodule

// File: tb/tb_bus_master_join.sv
// Bench for bus_master_join: directed and random commands against a
// schedule-level reference model of the join and error merge.
module tb_bus_master_join;
    localparam int N       = 4;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 100000;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic            rsp_valid, rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_err;
    logic [N-1:0]    slv_en;
    logic            req, req_write;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [N-1:0]    slv_done, slv_hit;
    logic [N*DW-1:0] slv_rdata;

    int tests = 0;
    int fails = 0;

    // Per-slave schedule, offsets counted in cycles from the first JOIN cycle.
    int            s_off   [N];
    logic          s_hit   [N];
    logic [DW-1:0] s_rd    [N];
    int            d_off   [N];
    logic          d_hit   [N];
    logic [DW-1:0] d_rd    [N];

    bus_master_join #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clock(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .slv_en(slv_en), .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .slv_done(slv_done), .slv_hit(slv_hit), .slv_rdata(slv_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < N; i++) begin
            s_off[i] = NEVER; s_hit[i] = 1'b0; s_rd[i] = '0;
            d_off[i] = NEVER; d_hit[i] = 1'b0; d_rd[i] = '0;
        end
    endtask

    // Expected response cycle (relative to accept cycle T), error code and read data.
    task automatic model(input logic wr, input logic [N-1:0] en,
                         output int cyc, output logic [1:0] err, output logic [DW-1:0] rd);
        int last = 0;
        int nh = 0;
        int low = -1;
        bit to = 0;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                if (s_off[i] > TIMEOUT - 1) to = 1;
                else if (s_off[i] > last) last = s_off[i];
                if (s_hit[i]) begin
                    nh++;
                    if (low < 0) low = i;
                end
            end
        end
        if (to) begin
            cyc = 2 + TIMEOUT; err = 2'd3; rd = '0;
        end else begin
            cyc = 2 + last + 1;
            err = (nh == 0) ? 2'd1 : (nh >= 2) ? 2'd2 : 2'd0;
            rd  = (wr || nh == 0) ? '0 : s_rd[low];
        end
    endtask

    task automatic run_cmd(input string name, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [N-1:0] en, input int hold);
        int            exp_cyc, cyc;
        logic [1:0]    exp_err;
        logic [DW-1:0] exp_rd;
        bit            got;
        model(wr, en, exp_cyc, exp_err, exp_rd);
        slv_en = en; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL %s cmd_ready_idle: got %b want 1", name, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_addr = '1; cmd_wdata = '1; cmd_write = ~wr;
        tests++;
        if (req !== 1'b1 || req_write !== wr || req_addr !== addr || req_wdata !== wdata) begin
            fails++;
            $display("FAIL %s issue: req=%b w=%b a=%h d=%h want 1 %b %h %h",
                     name, req, req_write, req_addr, req_wdata, wr, addr, wdata);
        end
        tick();
        cyc = 2; got = 0;
        while (!got && cyc < TIMEOUT + 8) begin
            if (rsp_valid === 1'b1) got = 1;
            else begin
                if (req !== 1'b0) begin
                    tests++; fails++; $display("FAIL %s req_extra: cycle %0d", name, cyc);
                end
                slv_done = '0; slv_hit = '0; slv_rdata = '0;
                for (int i = 0; i < N; i++) begin
                    if (cyc - 2 == s_off[i]) begin
                        slv_done[i] = 1'b1; slv_hit[i] = s_hit[i]; slv_rdata[i*DW +: DW] = s_rd[i];
                    end else if (cyc - 2 == d_off[i]) begin
                        slv_done[i] = 1'b1; slv_hit[i] = d_hit[i]; slv_rdata[i*DW +: DW] = d_rd[i];
                    end
                end
                tick();
                cyc++;
            end
        end
        slv_done = '0; slv_hit = '0; slv_rdata = '0;
        tests++;
        if (!got || cyc != exp_cyc) begin
            fails++; $display("FAIL %s latency: got T+%0d (seen=%0d) want T+%0d", name, cyc, got, exp_cyc);
        end
        if (got) begin
            for (int h = 0; h <= hold; h++) begin
                tests++;
                if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rd || cmd_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL %s resp[%0d]: v=%b err=%0d rd=%h rdy=%b want 1 %0d %h 0",
                             name, h, rsp_valid, rsp_err, rsp_rdata, cmd_ready, exp_err, exp_rd);
                end
                if (h < hold) tick();
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL %s back_to_idle: v=%b rdy=%b want 0 1", name, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; slv_en = '0; slv_done = '0; slv_hit = '0; slv_rdata = '0;
        repeat (3) tick();
        tests++;
        if (rsp_valid !== 0 || rsp_rdata !== 0 || rsp_err !== 0 || req !== 0 || req_write !== 0 ||
            req_addr !== 0 || req_wdata !== 0 || cmd_ready !== 0) begin
            fails++;
            $display("FAIL reset_outputs: v=%b rd=%h err=%0d req=%b w=%b a=%h d=%h rdy=%b want all 0",
                     rsp_valid, rsp_rdata, rsp_err, req, req_write, req_addr, req_wdata, cmd_ready);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_directed();
        clear_sched();
        s_off = '{0, 1, 1, 3}; s_hit[2] = 1'b1; s_rd[2] = 8'hEE;
        run_cmd("write_staggered", 1'b1, 8'h10, 8'hA5, 4'b1111, 0);

        clear_sched();
        s_off = '{0, 0, 0, 0}; s_hit[1] = 1'b1; s_rd[1] = 8'h5C; s_rd[0] = 8'h77;
        run_cmd("read_single_hit", 1'b0, 8'h20, 8'h00, 4'b1111, 0);

        clear_sched();
        s_off = '{1, 2, 0, 1}; s_hit[1] = 1'b1; s_rd[1] = 8'h11; s_hit[3] = 1'b1; s_rd[3] = 8'h33;
        run_cmd("read_multi_hit", 1'b0, 8'h30, 8'h00, 4'b1111, 0);

        clear_sched();
        s_off = '{0, 1, 2, 0};
        run_cmd("read_no_hit", 1'b0, 8'h40, 8'h00, 4'b1111, 0);
    endtask

    task automatic test_timeout();
        clear_sched();
        s_off = '{0, 1, 2, NEVER}; s_hit[0] = 1'b1; s_rd[0] = 8'h99;
        run_cmd("timeout", 1'b0, 8'h50, 8'h00, 4'b1111, 0);

        clear_sched();
        s_off = '{0, 1, 2, TIMEOUT - 1}; s_hit[3] = 1'b1; s_rd[3] = 8'h3C;
        run_cmd("done_on_timeout_cycle", 1'b0, 8'h51, 8'h00, 4'b1111, 0);
    endtask

    task automatic test_enable_mask();
        clear_sched();
        s_off = '{1, NEVER, 2, NEVER}; s_hit[2] = 1'b1; s_rd[2] = 8'h2A;
        d_off[0] = 2; d_hit[0] = 1'b1; d_rd[0] = 8'hBB;
        run_cmd("en_0101_dup", 1'b0, 8'h60, 8'h00, 4'b0101, 0);

        clear_sched();
        s_off = '{0, 0, 1, 2}; s_hit = '{1'b1, 1'b1, 1'b0, 1'b1};
        run_cmd("en_zero", 1'b0, 8'h61, 8'h00, 4'b0000, 0);
    endtask

    task automatic test_reset_mid_join();
        int seen = 0;
        slv_en = 4'b1111; cmd_write = 1'b1; cmd_addr = 8'h70; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if (rsp_valid !== 0 || rsp_rdata !== 0 || rsp_err !== 0 || req !== 0 || req_write !== 0 ||
            req_addr !== 0 || req_wdata !== 0 || cmd_ready !== 0) begin
            fails++;
            $display("FAIL reset_mid_join: v=%b err=%0d req=%b a=%h d=%h rdy=%b want all 0",
                     rsp_valid, rsp_err, req, req_addr, req_wdata, cmd_ready);
        end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            slv_done = 4'b1111; slv_hit = 4'b0010; slv_rdata = 32'hDEADBEEF;
            tick();
            if (rsp_valid !== 1'b0 || req !== 1'b0 || cmd_ready !== 1'b1) seen++;
        end
        slv_done = '0; slv_hit = '0; slv_rdata = '0;
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL late_done_after_reset: %0d bad cycles want 0", seen);
        end
    endtask

    task automatic test_hold();
        clear_sched();
        s_off = '{2, 0, 1, 0}; s_hit[3] = 1'b1; s_rd[3] = 8'hC3;
        run_cmd("rsp_hold_5", 1'b0, 8'h80, 8'h00, 4'b1111, 5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [N-1:0] en;
            logic         wr;
            clear_sched();
            en = N'($urandom);
            wr = 1'($urandom);
            for (int i = 0; i < N; i++) begin
                int r = int'($urandom_range(0, 19));
                s_off[i] = (r == 0) ? NEVER : (r == 1) ? TIMEOUT - 1 : (r == 2) ? TIMEOUT - 2 : r % 7;
                s_hit[i] = ($urandom_range(0, 2) == 0);
                s_rd[i]  = DW'($urandom);
                if ($urandom_range(0, 2) == 0 && s_off[i] < TIMEOUT) begin
                    d_off[i] = s_off[i] + 1 + int'($urandom_range(0, 2));
                    d_hit[i] = 1'($urandom);
                    d_rd[i]  = DW'($urandom);
                end
            end
            run_cmd($sformatf("random_%0d", n), wr, AW'($urandom), DW'($urandom), en,
                    int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_enable_mask();
        test_reset_mid_join();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
